// File: rtl/decode_execute_stage.sv
// ---------------------------------------------------------------------------
// decode_execute_stage
//
// D->E pipeline boundary for the 32-bit pipelined CPU. It holds the E-stage
// register, computes the forwarded E operands and detects the load-use
// hazard that holds fetch and decode.
//
// Ports
//   clk, rst_n              rising-edge clock, async active-low reset
//   rd1_d, rd2_d            register-file read data of the D instruction
//   ra1_d, ra2_d            D source addresses (4'hF = PC+8, already on rdX_d)
//   wa3_d                   D destination
//   regwrite_d, memtoreg_d  D writes a register / D is a load
//   ctrl_d                  opaque D control bundle (CTRL_W bits)
//   flush_e                 squash the instruction entering E
//   alures_m, wa3_m,
//   regwrite_m              M-stage forwarding source
//   result_w, wa3_w,
//   regwrite_w              W-stage forwarding source and register-file write
//   srca_e, srcb_e          forwarded E operands
//   wa3_e, regwrite_e,
//   memtoreg_e, ctrl_e      E-stage destination and control
//   stall_f, stall_d        hold PC / hold the decode register
// ---------------------------------------------------------------------------

// Per-operand datapath: decode bypass of the same-cycle W write and the
// M-over-W forwarding mux for the latched E operand.
module decode_execute_stage_fwd (
  input  logic [3:0]  ra_d,
  input  logic [31:0] rd_d,
  input  logic [3:0]  ra_e,
  input  logic [31:0] rd_e,
  input  logic        regwrite_m,
  input  logic [3:0]  wa3_m,
  input  logic [31:0] alures_m,
  input  logic        regwrite_w,
  input  logic [3:0]  wa3_w,
  input  logic [31:0] result_w,
  output logic [31:0] rd_byp_d,
  output logic [31:0] src_e
);
  localparam logic [3:0] RA_PC = 4'hF;

  logic hit_w_d, hit_m_e, hit_w_e;

  always_comb begin
    // The register file writes on the edge, so a W write in the same cycle
    // is missing from rd_d; take it straight from result_w instead.
    hit_w_d  = regwrite_w && (wa3_w == ra_d) && (ra_d != RA_PC);
    rd_byp_d = hit_w_d ? result_w : rd_d;
  end

  always_comb begin
    // R15 is PC+8 supplied by decode and never lives in the pipeline.
    hit_m_e = regwrite_m && (wa3_m == ra_e) && (ra_e != RA_PC);
    hit_w_e = regwrite_w && (wa3_w == ra_e) && (ra_e != RA_PC);
    if (hit_m_e)      src_e = alures_m;   // youngest producer wins
    else if (hit_w_e) src_e = result_w;
    else              src_e = rd_e;
  end
endmodule

module decode_execute_stage #(
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       rd1_d,
  input  logic [31:0]       rd2_d,
  input  logic [3:0]        ra1_d,
  input  logic [3:0]        ra2_d,
  input  logic [3:0]        wa3_d,
  input  logic              regwrite_d,
  input  logic              memtoreg_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              flush_e,
  input  logic [31:0]       alures_m,
  input  logic [3:0]        wa3_m,
  input  logic              regwrite_m,
  input  logic [31:0]       result_w,
  input  logic [3:0]        wa3_w,
  input  logic              regwrite_w,
  output logic [31:0]       srca_e,
  output logic [31:0]       srcb_e,
  output logic [3:0]        wa3_e,
  output logic              regwrite_e,
  output logic              memtoreg_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic              stall_f,
  output logic              stall_d
);
  localparam int         NUM_OPS = 2;
  localparam logic [3:0] RA_PC   = 4'hF;

  typedef struct packed {
    logic [31:0]       rd1;
    logic [31:0]       rd2;
    logic [3:0]        ra1;
    logic [3:0]        ra2;
    logic [3:0]        wa3;
    logic              regwrite;
    logic              memtoreg;
    logic [CTRL_W-1:0] ctrl;
  } ereg_t;

  ereg_t e_q, e_d;
  logic  ldstall;

  logic [NUM_OPS-1:0][3:0]  ra_d_v, ra_e_v;
  logic [NUM_OPS-1:0][31:0] rd_d_v, rd_e_v, rd_byp_v, src_v;

  assign ra_d_v = {ra2_d, ra1_d};
  assign rd_d_v = {rd2_d, rd1_d};
  assign ra_e_v = {e_q.ra2, e_q.ra1};
  assign rd_e_v = {e_q.rd2, e_q.rd1};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    decode_execute_stage_fwd u_fwd (
      .ra_d       (ra_d_v[g]),
      .rd_d       (rd_d_v[g]),
      .ra_e       (ra_e_v[g]),
      .rd_e       (rd_e_v[g]),
      .regwrite_m (regwrite_m),
      .wa3_m      (wa3_m),
      .alures_m   (alures_m),
      .regwrite_w (regwrite_w),
      .wa3_w      (wa3_w),
      .result_w   (result_w),
      .rd_byp_d   (rd_byp_v[g]),
      .src_e      (src_v[g])
    );
  end

  // A load in E cannot forward until it reaches W; any D read of its
  // destination must wait one cycle behind a bubble.
  always_comb begin
    ldstall = e_q.memtoreg && e_q.regwrite &&
              (((e_q.wa3 == ra1_d) && (ra1_d != RA_PC)) ||
               ((e_q.wa3 == ra2_d) && (ra2_d != RA_PC)));
  end

  // flush and ldstall together still insert just one bubble; the stalled D
  // instruction re-issues next cycle.
  always_comb begin
    e_d = '0;
    if (!(flush_e || ldstall)) begin
      e_d.rd1      = rd_byp_v[0];
      e_d.rd2      = rd_byp_v[1];
      e_d.ra1      = ra1_d;
      e_d.ra2      = ra2_d;
      e_d.wa3      = wa3_d;
      e_d.regwrite = regwrite_d;
      e_d.memtoreg = memtoreg_d;
      e_d.ctrl     = ctrl_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= '0;
    else        e_q <= e_d;
  end

  assign srca_e     = src_v[0];
  assign srcb_e     = src_v[1];
  assign wa3_e      = e_q.wa3;
  assign regwrite_e = e_q.regwrite;
  assign memtoreg_e = e_q.memtoreg;
  assign ctrl_e     = e_q.ctrl;
  assign stall_f    = ldstall;
  assign stall_d    = ldstall;
endmodule

// File: tb/tb_decode_execute_stage.sv
module tb_decode_execute_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rd1_d = '0, rd2_d = '0;
  logic [3:0]  ra1_d = '0, ra2_d = '0, wa3_d = '0;
  logic        regwrite_d = 1'b0, memtoreg_d = 1'b0;
  logic [11:0] ctrl_d = '0;
  logic        flush_e = 1'b0;
  logic [31:0] alures_m = '0;
  logic [3:0]  wa3_m = '0;
  logic        regwrite_m = 1'b0;
  logic [31:0] result_w = '0;
  logic [3:0]  wa3_w = '0;
  logic        regwrite_w = 1'b0;
  logic [31:0] srca_e, srcb_e;
  logic [3:0]  wa3_e;
  logic        regwrite_e, memtoreg_e, stall_f, stall_d;
  logic [11:0] ctrl_e;

  decode_execute_stage #(.CTRL_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
    .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .ctrl_d(ctrl_d),
    .flush_e(flush_e),
    .alures_m(alures_m), .wa3_m(wa3_m), .regwrite_m(regwrite_m),
    .result_w(result_w), .wa3_w(wa3_w), .regwrite_w(regwrite_w),
    .srca_e(srca_e), .srcb_e(srcb_e), .wa3_e(wa3_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .ctrl_e(ctrl_e),
    .stall_f(stall_f), .stall_d(stall_d)
  );

  always #5 clk = ~clk;

  // Instruction sitting in E, as the reference model sees it.
  typedef struct {
    logic [31:0] rd1, rd2;
    logic [3:0]  ra1, ra2, wa3;
    logic        rw, mtr;
    logic [11:0] ctrl;
  } instr_t;

  typedef struct {
    logic [31:0] srca, srcb;
    logic [3:0]  wa3;
    logic        rw, mtr, stall;
    logic [11:0] ctrl;
  } exp_t;

  instr_t in_e = '{default: '0};
  exp_t   sb[$];
  int     total = 0;
  int     bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Value a reader of register ra sees: the youngest in-flight producer,
  // else the value it already holds. R15 is PC+8 and never produced.
  function automatic logic [31:0] newest(input logic [3:0] ra, input logic [31:0] held,
                                         input bit use_m);
    logic [3:0]  pa[2];
    logic        pw[2];
    logic [31:0] pv[2];
    pa[0] = wa3_m; pw[0] = regwrite_m && use_m; pv[0] = alures_m;
    pa[1] = wa3_w; pw[1] = regwrite_w;          pv[1] = result_w;
    if (ra == 4'hF) return held;
    for (int i = 0; i < 2; i++)
      if (pw[i] && pa[i] == ra) return pv[i];
    return held;
  endfunction

  function automatic bit reads(input logic [3:0] ra, input logic [3:0] r);
    return (ra == r) && (ra != 4'hF);
  endfunction

  // One cycle: inputs already driven at this negedge. Push the expected
  // outputs, then advance the model across the rising edge.
  task automatic step();
    exp_t   e;
    instr_t nxt;
    bit     hazard;
    if (!rst_n) in_e = '{default: '0};
    hazard = in_e.mtr && in_e.rw && (reads(ra1_d, in_e.wa3) || reads(ra2_d, in_e.wa3));
    e.srca  = newest(in_e.ra1, in_e.rd1, 1'b1);
    e.srcb  = newest(in_e.ra2, in_e.rd2, 1'b1);
    e.wa3   = in_e.wa3;
    e.rw    = in_e.rw;
    e.mtr   = in_e.mtr;
    e.ctrl  = in_e.ctrl;
    e.stall = hazard;
    sb.push_back(e);
    if (!rst_n || flush_e || hazard) nxt = '{default: '0};
    else begin
      nxt.rd1 = newest(ra1_d, rd1_d, 1'b0);
      nxt.rd2 = newest(ra2_d, rd2_d, 1'b0);
      nxt.ra1 = ra1_d; nxt.ra2 = ra2_d; nxt.wa3 = wa3_d;
      nxt.rw = regwrite_d; nxt.mtr = memtoreg_d; nxt.ctrl = ctrl_d;
    end
    @(posedge clk);
    in_e = nxt;
    @(negedge clk);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("srca_e", srca_e, e.srca);
        chk("srcb_e", srcb_e, e.srcb);
        chk("wa3_e", {28'd0, wa3_e}, {28'd0, e.wa3});
        chk("regwrite_e", {31'd0, regwrite_e}, {31'd0, e.rw});
        chk("memtoreg_e", {31'd0, memtoreg_e}, {31'd0, e.mtr});
        chk("ctrl_e", {20'd0, ctrl_e}, {20'd0, e.ctrl});
        chk("stall_f", {31'd0, stall_f}, {31'd0, e.stall});
        chk("stall_d", {31'd0, stall_d}, {31'd0, e.stall});
      end
    end
  end

  task automatic quiet_mw();
    regwrite_m = 1'b0; regwrite_w = 1'b0; flush_e = 1'b0;
  endtask

  task automatic plain_d(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] wa);
    ra1_d = a1; ra2_d = a2; wa3_d = wa;
    regwrite_d = 1'b1; memtoreg_d = 1'b0; ctrl_d = 12'h0A5;
  endtask

  function automatic logic [3:0] rand_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'hF : 4'(r);
  endfunction

  initial begin
    @(negedge clk);
    // Reset with busy inputs: E stays a bubble, no stalls.
    rst_n = 1'b0;
    rd1_d = 32'hA5A5_0001; rd2_d = 32'h5A5A_0002; ra1_d = 4'd1; ra2_d = 4'd2;
    wa3_d = 4'd1; regwrite_d = 1'b1; memtoreg_d = 1'b1; ctrl_d = 12'hFFF;
    regwrite_m = 1'b1; wa3_m = 4'd6; alures_m = 32'h1;
    regwrite_w = 1'b1; wa3_w = 4'd7; result_w = 32'h2;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("rst_regwrite_e", {31'd0, regwrite_e}, 32'd0);
      chk("rst_memtoreg_e", {31'd0, memtoreg_e}, 32'd0);
      chk("rst_ctrl_e", {20'd0, ctrl_e}, 32'd0);
      chk("rst_stall", {30'd0, stall_f, stall_d}, 32'd0);
      step();
    end
    rst_n = 1'b1;
    quiet_mw();
    plain_d(4'd0, 4'd0, 4'd9);
    step();

    // M has priority over W.
    plain_d(4'd3, 4'd4, 4'd8); rd1_d = 32'h77; rd2_d = 32'h88;
    step();
    regwrite_m = 1'b1; wa3_m = 4'd3; alures_m = 32'hDEAD_BEEF;
    regwrite_w = 1'b1; wa3_w = 4'd3; result_w = 32'h11;
    #2 chk("fwd_m_prio", srca_e, 32'hDEAD_BEEF);
    step();
    regwrite_m = 1'b0;
    #2 chk("fwd_w", srca_e, 32'h11);
    step();

    // R15 is never forwarded.
    quiet_mw();
    plain_d(4'd0, 4'hF, 4'd8); rd2_d = 32'hCAFE_0008;
    step();
    regwrite_m = 1'b1; wa3_m = 4'hF; alures_m = 32'h0BAD;
    #2 chk("r15_excl", srcb_e, 32'hCAFE_0008);
    step();

    // Decode bypass of a same-cycle W write.
    quiet_mw();
    plain_d(4'd5, 4'd0, 4'd8); rd1_d = 32'h0;
    regwrite_w = 1'b1; wa3_w = 4'd5; result_w = 32'h1234;
    step();
    quiet_mw();
    #2 chk("dec_bypass", srca_e, 32'h1234);
    step();

    // Load-use: one stall, bubble, then W forwarding.
    plain_d(4'd0, 4'd0, 4'd2); memtoreg_d = 1'b1;
    step();
    plain_d(4'd0, 4'd2, 4'd7);
    #2 chk("ld_stall", {30'd0, stall_f, stall_d}, 32'd3);
    step();
    regwrite_m = 1'b1; wa3_m = 4'd2; alures_m = 32'h0999;
    #2 chk("ld_stall_off", {30'd0, stall_f, stall_d}, 32'd0);
    chk("ld_bubble", {31'd0, regwrite_e}, 32'd0);
    step();
    regwrite_m = 1'b0;
    regwrite_w = 1'b1; wa3_w = 4'd2; result_w = 32'h55;
    #2 chk("ld_enter", {31'd0, regwrite_e}, 32'd1);
    chk("ld_fwd_w", srcb_e, 32'h55);
    step();

    // Flush together with load-use: one bubble, one stall cycle.
    quiet_mw();
    plain_d(4'd0, 4'd0, 4'd2); memtoreg_d = 1'b1;
    step();
    plain_d(4'd2, 4'd0, 4'd6); flush_e = 1'b1;
    #2 chk("fl_stall", {30'd0, stall_f, stall_d}, 32'd3);
    step();
    flush_e = 1'b0;
    #2 chk("fl_stall_off", {30'd0, stall_f, stall_d}, 32'd0);
    chk("fl_bubble", {31'd0, regwrite_e}, 32'd0);
    step();
    #2 chk("fl_enter", {31'd0, regwrite_e}, 32'd1);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst_n      = ($urandom_range(0, 59) != 0);
      rd1_d      = $urandom; rd2_d = $urandom;
      ra1_d      = rand_reg(); ra2_d = rand_reg(); wa3_d = rand_reg();
      regwrite_d = 1'($urandom_range(0, 3) != 0);
      memtoreg_d = 1'($urandom_range(0, 2) == 0);
      ctrl_d     = 12'($urandom);
      flush_e    = ($urandom_range(0, 9) == 0);
      alures_m   = $urandom; wa3_m = rand_reg(); regwrite_m = 1'($urandom_range(0, 1));
      result_w   = $urandom; wa3_w = rand_reg(); regwrite_w = 1'($urandom_range(0, 1));
      step();
    end

    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
